// File: rtl/rv32i_types.sv
// rv32i_types: shared memory-responder FSM state type and latency limit
package rv32i_types;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;
    localparam int MEM_LAT_MAX = 15;
endpackage

// File: rtl/mem_array.sv
// mem_array: byte-lane-writable word array with combinational read, no reset
module mem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    assign rdata = mem[idx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: latency-programmable memory responder for the multicycle core's memory port
module mem_responder
    import rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);
    if (LATENCY < 1 || LATENCY > MEM_LAT_MAX || ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_param
        $error("mem_responder: LATENCY must be 1..15 and ADDR_WIDTH 1..29");
    end
    mem_resp_state_t       state, state_nxt;
    logic [3:0]            cnt;
    logic                  wr_q, err_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  req, req_err, live, commit, acc_wr, acc_err;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_wdata, arr_rdata;
    logic [3:0]            acc_be;
    assign req     = mem_read | mem_write;
    assign req_err = (mem_read & mem_write) | (|(mem_address >> (ADDR_WIDTH + 2)))
                   | (mem_write & ~|mem_byte_enable);
    always_comb begin
        state_nxt = state == IDLE ? (req ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
                  : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
                  : IDLE;
    end
    assign live      = state == IDLE;
    assign commit    = state_nxt == RESP && state != RESP;
    assign acc_wr    = live ? mem_write : wr_q;
    assign acc_err   = live ? req_err : err_q;
    assign acc_idx   = live ? mem_address[ADDR_WIDTH+1:2] : idx_q;
    assign acc_wdata = live ? mem_wdata : wdata_q;
    assign acc_be    = live ? mem_byte_enable : be_q;
    mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .we    (commit & acc_wr & ~acc_err),
        .be    (acc_be),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            mem_rdata <= 32'h0;
        end else begin
            if (live && req) begin
                cnt     <= 4'(LATENCY - 1);
                wr_q    <= mem_write;
                err_q   <= req_err;
                idx_q   <= mem_address[ADDR_WIDTH+1:2];
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_enable;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !acc_wr && !acc_err) mem_rdata <= arr_rdata;
        end
    end
    assign mem_resp = state == RESP;
    assign mem_err  = mem_resp & err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench over four responders with LATENCY 2, 1, 7, 15
module tb_mem_responder;
    localparam logic [3:0][3:0] LATS = {4'd15, 4'd7, 4'd1, 4'd2};
    typedef struct { logic err; logic [31:0] rdata; int due; } exp_t;
    typedef struct { bit r; bit w; logic [31:0] a; logic [31:0] d; logic [3:0] b; } op_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd [4];
    logic        wr [4];
    logic [3:0]  be [4];
    logic [31:0] addr [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata [4];
    logic        resp [4];
    logic        err [4];
    logic [31:0] last [4];
    logic [31:0] model [int];
    exp_t        sbq [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder #(.ADDR_WIDTH(8), .LATENCY(int'(LATS[g]))) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .mem_read        (rd[g]),
            .mem_write       (wr[g]),
            .mem_byte_enable (be[g]),
            .mem_address     (addr[g]),
            .mem_wdata       (wdata[g]),
            .mem_rdata       (rdata[g]),
            .mem_resp        (resp[g]),
            .mem_err         (err[g])
        );
    end

    task automatic drive(input int i, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input int extra);
        exp_t e;
        int k;
        logic [31:0] m;
        rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        e.err = (r && w) || (a[31:10] != 0) || (w && b == 4'h0);
        k = i * 1024 + int'(a[9:2]);
        e.rdata = last[i];
        if (!e.err && w) begin
            m = model.exists(k) ? model[k] : 32'h0;
            for (int n = 0; n < 4; n++) if (b[n]) m[8*n +: 8] = d[8*n +: 8];
            model[k] = m;
        end
        if (!e.err && r) e.rdata = model[k];
        last[i] = e.rdata;
        e.due = cyc + int'(LATS[i]) + extra;
        sbq.push_back(e);
    endtask

    task automatic wait_resp(input int i, output bit got, output int c);
        got = 0;
        c = -1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (resp[i]) begin got = 1; c = cyc; end
        end
    endtask

    task automatic release_req(input int i);
        rd[i] = 1'b0;
        wr[i] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            release_req(i);
            be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0; last[i] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d]: resp=%b err=%b rdata=%h, expected 0 0 00000000", i, resp[i], err[i], rdata[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_latency_lanes();
        op_t ops [$] = '{'{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF},
                         '{1'b0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100},
                         '{1'b1, 1'b0, 32'h10, 32'h0, 4'h0}};
        exp_t e; bit got; int c;
        foreach (ops[j]) begin
            drive(0, ops[j].r, ops[j].w, ops[j].a, ops[j].d, ops[j].b, 0);
            wait_resp(0, got, c);
            e = sbq.pop_front();
            checks++;
            if (!got || c !== e.due || err[0] !== e.err || rdata[0] !== e.rdata) begin
                errors++;
                $display("FAIL lat_lanes op%0d: got=%0b cyc=%0d err=%b rdata=%h, expected cyc=%0d err=%b rdata=%h",
                         j, got, c, err[0], rdata[0], e.due, e.err, e.rdata);
            end
            release_req(0);
            @(negedge clk);
            checks++;
            if (resp[0] !== 1'b0 || err[0] !== 1'b0 || rdata[0] !== last[0]) begin
                errors++;
                $display("FAIL lat_lanes pulse op%0d: resp=%b err=%b rdata=%h, expected 0 0 %h", j, resp[0], err[0], rdata[0], last[0]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rdata[0] !== 32'hDEAABEEF) begin
            errors++;
            $display("FAIL merged_hold: rdata=%h, expected deaabeef", rdata[0]);
        end
    endtask

    task automatic test_errors();
        op_t ops [$] = '{'{1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0},
                         '{1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF},
                         '{1'b0, 1'b1, 32'h10, 32'h11111111, 4'h0},
                         '{1'b1, 1'b0, 32'h10, 32'h0, 4'h0}};
        exp_t e; bit got; int c;
        foreach (ops[j]) begin
            drive(0, ops[j].r, ops[j].w, ops[j].a, ops[j].d, ops[j].b, 0);
            wait_resp(0, got, c);
            e = sbq.pop_front();
            checks++;
            if (!got || c !== e.due || err[0] !== e.err || rdata[0] !== e.rdata) begin
                errors++;
                $display("FAIL errors op%0d: got=%0b cyc=%0d err=%b rdata=%h, expected cyc=%0d err=%b rdata=%h",
                         j, got, c, err[0], rdata[0], e.due, e.err, e.rdata);
            end
            release_req(0);
            @(negedge clk);
            checks++;
            if (resp[0] !== 1'b0 || err[0] !== 1'b0) begin
                errors++;
                $display("FAIL errors pulse op%0d: resp=%b err=%b, expected 0 0", j, resp[0], err[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; bit got; int c, prev;
        op_t ops [4];
        for (int i = 1; i < 4; i++) begin
            ops[0] = '{1'b0, 1'b1, 32'h0, 32'hA000_0000 | 32'(i), 4'hF};
            ops[1] = '{1'b0, 1'b1, 32'h4, 32'hB000_0000 | 32'(i), 4'hF};
            ops[2] = '{1'b1, 1'b0, 32'h0, 32'h0, 4'h0};
            ops[3] = '{1'b1, 1'b0, 32'h4, 32'h0, 4'h0};
            prev = 0;
            for (int j = 0; j < 4; j++) begin
                drive(i, ops[j].r, ops[j].w, ops[j].a, ops[j].d, ops[j].b, j == 3 ? 1 : 0);
                wait_resp(i, got, c);
                e = sbq.pop_front();
                checks++;
                if (!got || c !== e.due || err[i] !== e.err || rdata[i] !== e.rdata) begin
                    errors++;
                    $display("FAIL b2b lat%0d op%0d: got=%0b cyc=%0d err=%b rdata=%h, expected cyc=%0d err=%b rdata=%h",
                             LATS[i], j, got, c, err[i], rdata[i], e.due, e.err, e.rdata);
                end
                if (j == 3) begin
                    checks++;
                    if (c - prev !== int'(LATS[i]) + 1) begin
                        errors++;
                        $display("FAIL b2b spacing lat%0d: spacing=%0d, expected %0d", LATS[i], c - prev, LATS[i] + 1);
                    end
                end
                prev = c;
                if (j != 2) begin
                    release_req(i);
                    @(negedge clk);
                    checks++;
                    if (resp[i] !== 1'b0 || rdata[i] !== last[i]) begin
                        errors++;
                        $display("FAIL b2b pulse lat%0d op%0d: resp=%b rdata=%h, expected 0 %h", LATS[i], j, resp[i], rdata[i], last[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e; bit got; int c; bit saw;
        op_t ops [2];
        ops[0] = '{1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF};
        ops[1] = '{1'b1, 1'b0, 32'h20, 32'h0, 4'h0};
        for (int j = 0; j < 2; j++) begin
            if (j == 1) begin
                rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h12345678; be[2] = 4'hF;
                repeat (3) @(negedge clk);
                rst_n = 1'b0;
                release_req(2);
                for (int i = 0; i < 4; i++) last[i] = 32'h0;
                @(negedge clk);
                rst_n = 1'b1;
                saw = 0;
                repeat (12) begin
                    @(negedge clk);
                    saw |= resp[2];
                end
                checks++;
                if (saw) begin
                    errors++;
                    $display("FAIL reset_mid: resp seen after reset, expected none");
                end
            end
            drive(2, ops[j].r, ops[j].w, ops[j].a, ops[j].d, ops[j].b, 0);
            wait_resp(2, got, c);
            e = sbq.pop_front();
            checks++;
            if (!got || c !== e.due || err[2] !== e.err || rdata[2] !== e.rdata) begin
                errors++;
                $display("FAIL reset_mid op%0d: got=%0b cyc=%0d err=%b rdata=%h, expected cyc=%0d err=%b rdata=%h",
                         j, got, c, err[2], rdata[2], e.due, e.err, e.rdata);
            end
            release_req(2);
            @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        exp_t e; bit got; int c;
        op_t ops [4];
        ops[0] = '{1'b0, 1'b1, 32'h34, 32'h55555555, 4'hF};
        ops[1] = '{1'b0, 1'b1, 32'h30, 32'h11111111, 4'hF};
        ops[2] = '{1'b1, 1'b0, 32'h30, 32'h0, 4'h0};
        ops[3] = '{1'b1, 1'b0, 32'h34, 32'h0, 4'h0};
        for (int j = 0; j < 4; j++) begin
            drive(2, ops[j].r, ops[j].w, ops[j].a, ops[j].d, ops[j].b, 0);
            if (j == 1) begin
                repeat (2) @(negedge clk);
                addr[2] = 32'h34;
                wdata[2] = 32'h22222222;
            end
            wait_resp(2, got, c);
            e = sbq.pop_front();
            checks++;
            if (!got || c !== e.due || err[2] !== e.err || rdata[2] !== e.rdata) begin
                errors++;
                $display("FAIL glitch op%0d: got=%0b cyc=%0d err=%b rdata=%h, expected cyc=%0d err=%b rdata=%h",
                         j, got, c, err[2], rdata[2], e.due, e.err, e.rdata);
            end
            release_req(2);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_latency_lanes();
        test_errors();
        test_back_to_back();
        test_reset_mid_wait();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
